// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run monitor: FSM state encoding and halt opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALTED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  // Opcode 6'b111111 with all other fields zero marks the end of a program.
  localparam logic [31:0] HALT_INST_DEFAULT = 32'hFC00_0000;

  // A new run may only be launched from a resting state.
  function automatic logic can_launch(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_HALTED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular buffer of the most recent program counters, read relative to the newest entry.
// Latency: push visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; when full the oldest entry is silently overwritten.
module trace_ring #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_dat,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W:0]    cnt;
  logic [IDX_W-1:0]  rd_ptr;

  // Write pointer wraps naturally (DEPTH is a power of two); count saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      if (cnt != (IDX_W+1)'(DEPTH)) begin
        cnt <= cnt + (IDX_W+1)'(1);
      end
    end
  end

  // Storage is not reset; entries beyond count are masked on the read side.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Index 0 is the most recently pushed entry, counting backwards from there.
  always_comb begin
    rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;
    rd_dat = '0;
    if ({1'b0, rd_idx} < cnt) begin
      rd_dat = mem[rd_ptr];
    end
  end

  assign count = cnt;

endmodule

// File: rtl/cpu_run_monitor.sv
// Launches a CPU run (reset hold, then release), counts run cycles, traces PCs, detects halt/timeout.
// Latency: cpu_reset stays high RESET_CYCLES cycles after start; halt/timeout seen one edge after the cycle.
// Backpressure: none; start is ignored while a run is holding or running.
module cpu_run_monitor
  import cpu_run_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                RESET_CYCLES = 2,
  parameter int                MAX_CYCLES   = 1000,
  parameter int                TRACE_DEPTH  = 8,
  parameter logic [DATA_W-1:0] HALT_INST    = DATA_W'(HALT_INST_DEFAULT)
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              currentAddress,
  input  logic [DATA_W-1:0]              inst,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic                           cpu_reset,
  output logic [2:0]                     state,
  output logic [31:0]                    cycle_count,
  output logic                           done,
  output logic                           timeout,
  output logic [ADDR_W-1:0]              trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

  run_state_e  state_q, state_d;
  logic [31:0] hold_q;
  logic [31:0] cycle_q;
  logic [31:0] cycle_inc;
  logic        launch;
  logic        run_cycle;
  logic        is_halt;
  logic        hit_limit;

  assign is_halt   = (inst == HALT_INST);
  assign cycle_inc = cycle_q + 32'd1;
  assign hit_limit = (cycle_inc == 32'(MAX_CYCLES));

  // Next-state selection and state-decoded outputs; halt wins over timeout.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    run_cycle = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        done    = (state_q == ST_HALTED);
        timeout = (state_q == ST_TIMEOUT);
        if (start && can_launch(state_q)) begin
          state_d = ST_HOLD;
          launch  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == 32'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        run_cycle = 1'b1;
        if (is_halt) begin
          state_d = ST_HALTED;
        end else if (hit_limit) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; Reset overrides any pending start.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold-phase timer and run-cycle counter; both freeze outside HOLD/RUN.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      hold_q  <= '0;
      cycle_q <= '0;
    end else if (launch) begin
      hold_q  <= '0;
      cycle_q <= '0;
    end else if (state_q == ST_HOLD) begin
      hold_q  <= hold_q + 32'd1;
    end else if (run_cycle) begin
      cycle_q <= cycle_inc;
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_q;

  trace_ring #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace_ring (
    .clk      (CLK),
    .rst      (Reset),
    .clr      (launch),
    .push     (run_cycle),
    .push_dat (currentAddress),
    .rd_idx   (trace_idx),
    .rd_dat   (trace_pc),
    .count    (trace_count)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed scenarios, then randomized traffic vs a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_run_monitor;
  import cpu_run_pkg::*;

  localparam int          RC   = 2;
  localparam int          MC   = 16;
  localparam int          TD   = 4;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [31:0] currentAddress;
  logic [31:0] inst;
  logic [1:0]  trace_idx;
  logic        cpu_reset;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic        done;
  logic        timeout;
  logic [31:0] trace_pc;
  logic [2:0]  trace_count;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: phase, remaining hold cycles, run count, and the PCs of the current run.
  run_state_e  m_st;
  int          m_hold;
  int          m_cnt;
  logic [31:0] m_q[$];

  always #5 CLK = ~CLK;

  cpu_run_monitor #(
    .ADDR_W(32), .DATA_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MC), .TRACE_DEPTH(TD), .HALT_INST(HALT)
  ) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .currentAddress(currentAddress), .inst(inst),
    .trace_idx(trace_idx), .cpu_reset(cpu_reset), .state(state), .cycle_count(cycle_count),
    .done(done), .timeout(timeout), .trace_pc(trace_pc), .trace_count(trace_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_pc(input int idx);
    int n = (m_q.size() < TD) ? m_q.size() : TD;
    if (idx < n) return m_q[m_q.size() - 1 - idx];
    return 32'd0;
  endfunction

  task automatic compare_all();
    int n = (m_q.size() < TD) ? m_q.size() : TD;
    check("state",       state,       m_st);
    check("cpu_reset",   cpu_reset,   (m_st != ST_RUN));
    check("cycle_count", cycle_count, m_cnt);
    check("done",        done,        (m_st == ST_HALTED));
    check("timeout",     timeout,     (m_st == ST_TIMEOUT));
    check("trace_count", trace_count, n);
    check("trace_pc",    trace_pc,    model_pc(int'(trace_idx)));
  endtask

  task automatic model_step(input bit r, input bit s, input logic [31:0] pc, input logic [31:0] ins);
    if (r) begin
      m_st = ST_IDLE; m_cnt = 0; m_q.delete();
    end else if (m_st == ST_HOLD) begin
      m_hold--;
      if (m_hold == 0) m_st = ST_RUN;
    end else if (m_st == ST_RUN) begin
      m_cnt++;
      m_q.push_back(pc);
      if (m_q.size() > TD) void'(m_q.pop_front());
      if (ins == HALT)      m_st = ST_HALTED;
      else if (m_cnt == MC) m_st = ST_TIMEOUT;
    end else if (s) begin
      m_st = ST_HOLD; m_hold = RC; m_cnt = 0; m_q.delete();
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic cyc(input bit r, input bit s, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [1:0] idx);
    Reset = r; start = s; currentAddress = pc; inst = ins; trace_idx = idx;
    #1;
    compare_all();
    model_step(r, s, pc, ins);
    @(posedge CLK);
    #1;
  endtask

  task automatic launch_run();
    cyc(0, 1, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < RC; i++) cyc(0, 0, 32'h0, 32'h0, 2'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; currentAddress = '0; inst = '0; trace_idx = '0;
    m_st = ST_IDLE; m_hold = 0; m_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state",     state,       ST_IDLE);
    check("rst_cpu_reset", cpu_reset,   1'b1);
    check("rst_count",     cycle_count, 32'd0);
    check("rst_trace_cnt", trace_count, 3'd0);

    // Start pulse, hold for RC cycles, then release.
    cyc(0, 0, 32'h0, 32'h0, 2'd0);
    launch_run();
    check("hold_release_state", state, ST_RUN);
    check("hold_release_rst",   cpu_reset, 1'b0);

    // Six run cycles, PCs 0..20, halt on the sixth.
    for (int i = 0; i < 6; i++) cyc(0, (i == 2), 32'(4 * i), (i == 5) ? HALT : 32'h0, 2'(i));
    Reset = 0; start = 0; trace_idx = 2'd0; #1;
    check("halt_done",   done,        1'b1);
    check("halt_count",  cycle_count, 32'd6);
    check("halt_tcount", trace_count, 3'd4);
    check("halt_pc0",    trace_pc,    32'd20);
    trace_idx = 2'd3; #1;
    check("halt_pc3",    trace_pc,    32'd8);
    cyc(0, 0, 32'h0, 32'h0, 2'd1);

    // Start from HALTED clears trace and done; then run to timeout with start ignored mid-run.
    cyc(0, 1, 32'h0, 32'h0, 2'd0);
    check("restart_tcount", trace_count, 3'd0);
    check("restart_done",   done,        1'b0);
    check("restart_state",  state,       ST_HOLD);
    for (int i = 0; i < RC; i++) cyc(0, 0, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < MC; i++) cyc(0, (i % 5 == 1), 32'h100 + 32'(i), 32'h1234, 2'(i));
    #1;
    check("to_timeout", timeout,     1'b1);
    check("to_cpu_rst", cpu_reset,   1'b1);
    check("to_count",   cycle_count, 32'd16);
    cyc(0, 0, 32'h0, 32'h0, 2'd0);

    // Halt coinciding with the limit: halt wins.
    launch_run();
    for (int i = 0; i < MC; i++) cyc(0, 0, 32'h200 + 32'(i), (i == MC - 1) ? HALT : 32'h0, 2'd0);
    #1;
    check("prio_done",    done,        1'b1);
    check("prio_timeout", timeout,     1'b0);
    check("prio_count",   cycle_count, 32'd16);
    cyc(0, 0, 32'h0, 32'h0, 2'd0);

    // Reset during the fifth run cycle.
    launch_run();
    for (int i = 0; i < 5; i++) cyc((i == 4), 0, 32'h300 + 32'(i), 32'h0, 2'd0);
    #1;
    check("midrst_state",  state,       ST_IDLE);
    check("midrst_count",  cycle_count, 32'd0);
    check("midrst_tcount", trace_count, 3'd0);
    check("midrst_cpurst", cpu_reset,   1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r   = ($urandom_range(0, 99) == 0);
      bit          s   = ($urandom_range(0, 4) == 0);
      logic [31:0] pc  = $urandom();
      logic [31:0] ins = ($urandom_range(0, 9) == 0) ? HALT : $urandom();
      cyc(r, s, pc, ins, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter ADDR_W, 32, width of the sampled CPU program counter.
REQ-002 Parameter DATA_W, 32, width of the sampled CPU instruction word.
REQ-003 Parameter RESET_CYCLES, 2, number of cycles cpu_reset is held high after start (minimum 1).
REQ-004 Parameter MAX_CYCLES, 1000, number of run cycles without halt before timeout (minimum 1).
REQ-005 Parameter TRACE_DEPTH, 8, number of PC trace entries (power of two, minimum 2).
REQ-006 Parameter HALT_INST, 32'hFC000000, instruction word that signals halt (opcode 6'b111111).
REQ-007 The block SHALL have one clock; reset is synchronous and active-high. The ports are CLK and Reset.
REQ-008 CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-009 Reset  input  1  synchronous active-high reset.
REQ-010 start  input  1  single-cycle request to begin a CPU run.
REQ-011 currentAddress  input  ADDR_W  PC of the CPU under control.
REQ-012 inst  input  DATA_W  instruction currently fetched by the CPU.
REQ-013 trace_idx  input  $clog2(TRACE_DEPTH)  trace read index; 0 selects the newest entry.
REQ-014 cpu_reset  output  1  drives the Reset input of the controlled CPU.
REQ-015 state  output  3  encoded FSM state.
REQ-016 cycle_count  output  32  number of run cycles in the current run.
REQ-017 done  output  1  high while in HALTED.
REQ-018 timeout  output  1  high while in TIMEOUT.
REQ-019 trace_pc  output  ADDR_W  PC at trace_idx, read combinationally.
REQ-020 trace_count  output  $clog2(TRACE_DEPTH)+1  number of valid trace entries.

Function
REQ-021 FSM states SHALL be IDLE, HOLD, RUN, HALTED and TIMEOUT.
REQ-022 cpu_reset SHALL be 1 in IDLE, HOLD, HALTED and TIMEOUT, and 0 only in RUN.
REQ-023 IDLE, HALTED or TIMEOUT with start=1 SHALL go to HOLD and clear cycle_count, trace_count, done and timeout.
REQ-024 HOLD SHALL last exactly RESET_CYCLES cycles and then go to RUN.
REQ-025 start SHALL be ignored in HOLD and RUN.
REQ-026 Each RUN cycle SHALL increment cycle_count and push currentAddress into the trace ring.
REQ-027 trace_count SHALL saturate at TRACE_DEPTH; when full, the oldest entry is overwritten.
REQ-028 In a RUN cycle with inst==HALT_INST, the FSM SHALL go to HALTED on the next edge; that cycle is counted and traced.
REQ-029 In a RUN cycle where the incremented cycle_count equals MAX_CYCLES and inst!=HALT_INST, the FSM SHALL go to TIMEOUT.
REQ-030 If halt and the timeout condition occur in the same cycle, halt SHALL take priority (HALTED, timeout=0).
REQ-031 In HALTED and TIMEOUT, cycle_count and trace contents SHALL remain frozen.
REQ-032 trace_pc SHALL be 0 when trace_idx>=trace_count.
REQ-033 cycle_count SHALL never exceed MAX_CYCLES.

Reset
REQ-034 Reset=1 SHALL, at the next edge and from any state (including mid-RUN), force: state=IDLE, cpu_reset=1, cycle_count=0, trace_count=0, done=0, timeout=0, write pointer=0.
REQ-035 Reset SHALL take priority over start.

Structure
REQ-036 Package cpu_run_pkg SHALL hold the state enum encoding and the default HALT_INST constant.
REQ-037 Sub-module trace_ring SHALL implement the circular PC buffer: push, saturating count, newest-relative read.

Verification (RESET_CYCLES=2, MAX_CYCLES=16, TRACE_DEPTH=4)
REQ-038 Reset, then start pulse -> cpu_reset stays 1 for exactly 2 cycles after start, then 0; state=RUN.
REQ-039 PC 0,4,...,20 with HALT_INST on run cycle 6 -> done=1, cycle_count=6, trace_count=4, trace_pc[0]=20, trace_pc[3]=8.
REQ-040 No halt -> timeout=1 and cpu_reset=1 after 16 run cycles; cycle_count=16.
REQ-041 HALT_INST on run cycle 16 -> done=1, timeout=0, cycle_count=16.
REQ-042 Reset asserted on run cycle 5 -> next cycle state=IDLE, cycle_count=0, trace_count=0, cpu_reset=1.
REQ-043 start during RUN -> no effect; start in HALTED -> HOLD, trace_count=0, done=0.
